instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the instruction decode path: accepts decoded RV32I instruction fields (format, opcode, funct3, funct7, register indices, immediate) over a valid/ready handshake.
- Packs the fields into 32-bit instruction words and buffers them in a small FIFO.
- Streams the words to the instruction-memory write port at auto-incrementing word addresses.
- Used by the bench/boot loader to build program images for the single-cycle and pipelined cores.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- ADDR_W, 32, width of the instruction-memory byte address.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- addr_load  in  1  load base address into the write-address counter
- base_addr  in  ADDR_W  value loaded by addr_load
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 invalid
- opcode  in  7  opcode_e value
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- imm  in  32  sign-extended immediate (byte offset for B/J, full value for U)
- out_valid  out  1  word available for memory write
- out_ready  in  1  memory accepts the write
- out_addr  out  ADDR_W  byte address of the word
- out_data  out  32  encoded instruction
- words_written  out  16  count of completed writes, wraps
- fmt_err  out  1  sticky: invalid fmt seen
- imm_err  out  1  sticky: immediate out of range (optional feature)

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_addr=0, out_data=0, words_written=0, fmt_err=0, imm_err=0. FIFO is empty.
- Encoding is combinational on the input fields. The word is pushed on in_valid && in_ready.
- Field packing:
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
  - Fields unused by a format are ignored.
- fmt 6/7: the pushed word is NOP 0x00000013 and fmt_err is set. fmt_err clears only on reset.
- in_ready = FIFO not full. A push while full is impossible; there is no push-through-on-pop when full.
- out_valid = FIFO not empty. out_data = head entry. out_addr = address counter.
- Latency: a bundle accepted in cycle N is presented at the output in cycle N+1 if the FIFO was empty.
- Pop on out_valid && out_ready:
  - head advances;
  - out_addr += 4, wrapping modulo 2^ADDR_W;
  - words_written += 1, wrapping at 16 bits.
- Simultaneous push and pop with the FIFO neither full nor empty: occupancy is unchanged and both take effect.
- Push and pop while at one entry: the head pops and the new word becomes the head next cycle.
- Read/write pointers wrap modulo DEPTH. Occupancy counter width is log2(DEPTH)+1.
- addr_load:
  - loads base_addr into the address counter and overrides the +4 of a simultaneous pop (load wins);
  - does not flush the FIFO and does not affect words_written.
- out_valid, out_addr and out_data remain stable while out_valid && !out_ready.
- Reset asserted mid-stream empties the FIFO immediately and returns all outputs to their reset values. Buffered words are discarded.

Optional Feature:
- Macro: INSTR_ENCODER_IMM_CHECK_EN.
- Defined: on push, the immediate is checked for representability. A violation sets sticky imm_err; the word is still encoded with truncated fields. Rules:
  - I/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094] and imm[0]=0.
  - J: imm in [-1048576, 1048574] and imm[0]=0.
  - U: imm[11:0]=0.
  - R: not checked.
- Undefined: the checker logic is absent and imm_err is tied to 0.

Test Plan:
- Reset, addr_load base 0x100, push I op=0x13 f3=0 rd=1 rs1=0 imm=5 -> next cycle out_valid=1, out_addr=0x100, out_data=0x00500093; after pop out_addr=0x104, words_written=1.
- Push R add x3,x1,x2 (op 0x33) and then S sw x2,8(x1) (op 0x23 f3=2) back-to-back with out_ready=1 -> 0x002081B3 @0x104, 0x0020A423 @0x108.
- Push B beq x0,x0,-4 (op 0x63) and J jal x1,16 (op 0x6F) -> 0xFE000EE3 and 0x010000EF.
- Hold out_ready=0 and push DEPTH bundles -> in_ready=0 after the DEPTH-th accept and outputs stable; raise out_ready -> in_ready=1 the following cycle and words drain in order with no loss or duplicate.
- Push fmt=7 -> out_data=0x00000013 and fmt_err=1 until reset. With INSTR_ENCODER_IMM_CHECK_EN defined, push I imm=4096 -> imm_err=1 and out_data=0x00000093.
- Assert rst_n low with 3 words buffered -> out_valid=0, out_addr=0, words_written=0 asynchronously; no stale word after release.

Source files
------------

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into instruction words, buffers them in a small FIFO and streams
// them to the instruction-memory write port. Optional immediate range checker: INSTR_ENCODER_IMM_CHECK_EN.
module instr_encoder #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              addr_load,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        fmt,
   input  logic [6:0]        opcode,
   input  logic [2:0]        funct3,
   input  logic [6:0]        funct7,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [31:0]       imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [31:0]       out_data,
   output logic [15:0]       words_written,
   output logic              fmt_err,
   output logic              imm_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [2:0]  FMT_R = 3'd0;
   localparam logic [2:0]  FMT_I = 3'd1;
   localparam logic [2:0]  FMT_S = 3'd2;
   localparam logic [2:0]  FMT_B = 3'd3;
   localparam logic [2:0]  FMT_U = 3'd4;
   localparam logic [2:0]  FMT_J = 3'd5;
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   // ------------------------------------------------------------------
   // Field packing
   // ------------------------------------------------------------------
   logic [31:0] enc_word;
   logic        fmt_invalid;

   always_comb begin
      enc_word    = NOP_WORD;
      fmt_invalid = 1'b0;
      case (fmt)
         FMT_R:   enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I:   enc_word = {imm[11:0], rs1, funct3, rd, opcode};
         FMT_S:   enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
         FMT_B:   enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
         FMT_U:   enc_word = {imm[31:12], rd, opcode};
         FMT_J:   enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
         default: fmt_invalid = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------
   // FIFO control
   // ------------------------------------------------------------------
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             push, pop;

   assign in_ready  = (count_reg != CNT_W'(DEPTH));
   assign out_valid = (count_reg != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // Pointers rely on DEPTH being a power of two to wrap naturally.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (push) begin
         wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Storage carries no reset; emptiness is tracked entirely by count_reg.
   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= enc_word;
      end
   end

   assign out_data = out_valid ? mem[rd_ptr_reg] : 32'h0;

   // ------------------------------------------------------------------
   // Write address, completion counter and sticky error flags
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [15:0]       written_reg, written_next;
   logic              fmt_err_reg, fmt_err_next;

   always_comb begin
      addr_next    = addr_reg;
      written_next = written_reg;
      fmt_err_next = fmt_err_reg;
      if (pop) begin
         addr_next    = addr_reg + ADDR_W'(4);
         written_next = written_reg + 16'd1;
      end
      // A base load takes priority over the post-pop increment.
      if (addr_load) begin
         addr_next = base_addr;
      end
      if (push && fmt_invalid) begin
         fmt_err_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg    <= '0;
         written_reg <= '0;
         fmt_err_reg <= 1'b0;
      end else begin
         addr_reg    <= addr_next;
         written_reg <= written_next;
         fmt_err_reg <= fmt_err_next;
      end
   end

   assign out_addr      = addr_reg;
   assign words_written = written_reg;
   assign fmt_err       = fmt_err_reg;

`ifdef INSTR_ENCODER_IMM_CHECK_EN
   logic imm_bad;
   logic imm_err_reg, imm_err_next;

   // An immediate fits N signed bits when every bit above bit N-2 equals the sign bit.
   always_comb begin
      imm_bad = 1'b0;
      case (fmt)
         FMT_I, FMT_S: imm_bad = !((&imm[31:11]) || !(|imm[31:11]));
         FMT_B:        imm_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
         FMT_J:        imm_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
         FMT_U:        imm_bad = |imm[11:0];
         default:      imm_bad = 1'b0;
      endcase
   end

   always_comb begin
      imm_err_next = imm_err_reg;
      if (push && imm_bad) begin
         imm_err_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imm_err_reg <= 1'b0;
      end else begin
         imm_err_reg <= imm_err_next;
      end
   end

   assign imm_err = imm_err_reg;
`else
   assign imm_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed program-image vectors followed by randomized
// traffic compared each cycle against a queue-based reference model.
module tb_instr_encoder;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              addr_load = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [2:0]        fmt = '0;
   logic [6:0]        opcode = '0;
   logic [2:0]        funct3 = '0;
   logic [6:0]        funct7 = '0;
   logic [4:0]        rd = '0;
   logic [4:0]        rs1 = '0;
   logic [4:0]        rs2 = '0;
   logic [31:0]       imm = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [ADDR_W-1:0] out_addr;
   logic [31:0]       out_data;
   logic [15:0]       words_written;
   logic              fmt_err;
   logic              imm_err;

   always #5 clk = ~clk;

   instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .addr_load(addr_load), .base_addr(base_addr),
      .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
      .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_data(out_data), .words_written(words_written), .fmt_err(fmt_err),
      .imm_err(imm_err)
   );

   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model state
   logic [31:0] m_q[$];
   logic [31:0] m_addr;
   logic [15:0] m_cnt;
   bit          m_fmt_err;
   bit          m_imm_err;

   task automatic model_reset();
      m_q.delete();
      m_addr    = '0;
      m_cnt     = '0;
      m_fmt_err = 0;
      m_imm_err = 0;
   endtask

   function automatic int bits(input logic [31:0] v, input int hi, input int lo);
      return int'((v >> lo) & ((32'h1 << (hi - lo + 1)) - 1));
   endfunction

   // Builds the word by placing each field at its bit position with shifts and adds.
   function automatic logic [31:0] ref_encode(input logic [2:0] f, input logic [6:0] op,
         input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] d,
         input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
      logic [31:0] w;
      logic [31:0] common;
      common = (32'(f3) << 12) + 32'(op);
      case (f)
         3'd0: w = common + (32'(f7) << 25) + (32'(s2) << 20) + (32'(s1) << 15) + (32'(d) << 7);
         3'd1: w = common + (32'(bits(im, 11, 0)) << 20) + (32'(s1) << 15) + (32'(d) << 7);
         3'd2: w = common + (32'(bits(im, 11, 5)) << 25) + (32'(s2) << 20) + (32'(s1) << 15)
                   + (32'(bits(im, 4, 0)) << 7);
         3'd3: w = common + (32'(bits(im, 12, 12)) << 31) + (32'(bits(im, 10, 5)) << 25)
                   + (32'(s2) << 20) + (32'(s1) << 15) + (32'(bits(im, 4, 1)) << 8)
                   + (32'(bits(im, 11, 11)) << 7);
         3'd4: w = (im & 32'hFFFF_F000) + (32'(d) << 7) + 32'(op);
         3'd5: w = (32'(bits(im, 20, 20)) << 31) + (32'(bits(im, 10, 1)) << 21)
                   + (32'(bits(im, 11, 11)) << 20) + (32'(bits(im, 19, 12)) << 12)
                   + (32'(d) << 7) + 32'(op);
         default: w = 32'h0000_0013;
      endcase
      return w;
   endfunction

   function automatic bit ref_imm_bad(input logic [2:0] f, input logic [31:0] im);
      int si;
      si = $signed(im);
      case (f)
         3'd1, 3'd2: return (si < -2048) || (si > 2047);
         3'd3:       return (si < -4096) || (si > 4094) || (si % 2 != 0);
         3'd5:       return (si < -1048576) || (si > 1048574) || (si % 2 != 0);
         3'd4:       return (im % 4096) != 0;
         default:    return 0;
      endcase
   endfunction

   task automatic check_outputs(input string ctx);
      check({ctx, ".in_ready"},  in_ready,  m_q.size() < DEPTH);
      check({ctx, ".out_valid"}, out_valid, m_q.size() != 0);
      check({ctx, ".out_data"},  out_data,  (m_q.size() != 0) ? m_q[0] : 32'h0);
      check({ctx, ".out_addr"},  out_addr,  m_addr);
      check({ctx, ".words"},     words_written, m_cnt);
      check({ctx, ".fmt_err"},   fmt_err,   m_fmt_err);
`ifdef INSTR_ENCODER_IMM_CHECK_EN
      check({ctx, ".imm_err"},   imm_err,   m_imm_err);
`else
      check({ctx, ".imm_err"},   imm_err,   1'b0);
`endif
   endtask

   task automatic set_fields(input bit v, input logic [2:0] f, input logic [6:0] op,
         input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] d,
         input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
      in_valid = v; fmt = f; opcode = op; funct3 = f3; funct7 = f7;
      rd = d; rs1 = s1; rs2 = s2; imm = im;
   endtask

   task automatic idle();
      set_fields(0, 3'd0, 7'h0, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0);
   endtask

   // Called at a negedge with inputs already driven; advances one clock and checks.
   task automatic cycle(input string ctx);
      bit          push, pop, bad;
      logic [31:0] w;
      push = in_valid && (m_q.size() < DEPTH);
      pop  = out_ready && (m_q.size() != 0);
      w    = ref_encode(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm);
      bad  = ref_imm_bad(fmt, imm);
      @(posedge clk);
      if (pop) begin
         $display("[TB] write @0x%08h data 0x%08h", m_addr, m_q[0]);
         void'(m_q.pop_front());
         m_cnt++;
         m_addr += 32'd4;
      end
      if (addr_load) m_addr = base_addr;
      if (push) begin
         m_q.push_back(w);
         if (fmt > 3'd5) m_fmt_err = 1;
         if (bad) m_imm_err = 1;
      end
      @(negedge clk);
      check_outputs(ctx);
   endtask

   initial begin
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // I-type addi x1,x0,5 at base 0x100
      addr_load = 1; base_addr = 32'h100; out_ready = 0;
      set_fields(1, 3'd1, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd5);
      cycle("tp_addi");
      addr_load = 0; idle();
      check("tp_addi_data", out_data, 32'h0050_0093);
      check("tp_addi_addr", out_addr, 32'h100);
      out_ready = 1;
      cycle("tp_pop1");
      check("tp_pop1_addr", out_addr, 32'h104);
      check("tp_pop1_words", words_written, 16'd1);

      // R add then S sw back-to-back with out_ready high
      set_fields(1, 3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0);
      cycle("tp_add");
      check("tp_add_data", out_data, 32'h0020_81B3);
      check("tp_add_addr", out_addr, 32'h104);
      set_fields(1, 3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8);
      cycle("tp_sw");
      check("tp_sw_data", out_data, 32'h0020_A423);
      check("tp_sw_addr", out_addr, 32'h108);

      // B beq x0,x0,-4 and J jal x1,16
      set_fields(1, 3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
      cycle("tp_beq");
      check("tp_beq_data", out_data, 32'hFE00_0EE3);
      set_fields(1, 3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd16);
      cycle("tp_jal");
      check("tp_jal_data", out_data, 32'h0100_00EF);
      idle();
      cycle("tp_drain");

      // Fill with out_ready low, then hold with in_valid still asserted
      out_ready = 0;
      for (int i = 0; i < DEPTH; i++) begin
         set_fields(1, 3'd1, 7'h13, 3'd0, 7'h0, 5'(i + 1), 5'd0, 5'd0, 32'(i));
         cycle("tp_fill");
      end
      check("tp_full_ready", in_ready, 1'b0);
      set_fields(1, 3'd1, 7'h13, 3'd0, 7'h0, 5'd9, 5'd0, 5'd0, 32'd99);
      for (int i = 0; i < 3; i++) cycle("tp_hold");
      check("tp_hold_data", out_data, 32'h0000_0093);
      idle();
      out_ready = 1;
      cycle("tp_release");
      check("tp_release_ready", in_ready, 1'b1);
      for (int i = 0; i < DEPTH; i++) cycle("tp_drain_full");

      // Invalid format and immediate range
      set_fields(1, 3'd7, 7'h33, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, 32'h1234);
      out_ready = 0;
      cycle("tp_fmt7");
      check("tp_fmt7_data", out_data, 32'h0000_0013);
      check("tp_fmt7_err", fmt_err, 1'b1);
      out_ready = 1;
      set_fields(1, 3'd1, 7'h13, 3'd0, 7'h0, 5'd1, 5'd0, 5'd0, 32'd4096);
      cycle("tp_imm4096");
      check("tp_imm4096_data", out_data, 32'h0000_0093);
`ifdef INSTR_ENCODER_IMM_CHECK_EN
      check("tp_imm4096_err", imm_err, 1'b1);
`endif
      idle();
      cycle("tp_drain2");

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [2:0]  rf;
         logic [31:0] r, ri;
         r = $urandom;
         rf = ($urandom_range(0, 15) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
         case ($urandom_range(0, 3))
            0:       ri = $urandom;
            1:       ri = {{20{r[11]}}, r[11:0]};
            2:       ri = {{19{r[12]}}, r[12:1], 1'b0};
            default: ri = {r[31:12], 12'h0};
         endcase
         set_fields($urandom_range(0, 3) != 0, rf, 7'($urandom), 3'($urandom), 7'($urandom),
                    5'($urandom), 5'($urandom), 5'($urandom), ri);
         out_ready = $urandom_range(0, 2) != 0;
         addr_load = $urandom_range(0, 31) == 0;
         base_addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         cycle("rand");
      end
      addr_load = 0;

      // Asynchronous reset with three words buffered
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         set_fields(1, 3'd0, 7'h33, 3'd0, 7'h0, 5'(i), 5'd1, 5'd2, 32'h0);
         cycle("tp_pre_rst");
      end
      idle();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs("tp_async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1;
      for (int i = 0; i < 3; i++) cycle("tp_post_rst");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
